axil_csr_responder: RTL and testbench
=====================================

Name: axil_csr_responder

Overview:
- Synthesizable AXI4-Lite responder (slave) for the PS-to-PL GP port.
- This is the far end of the host's AXI-Lite initiator used in cosim.
- Provides a bank of software-writable CSRs, a PS->PL word FIFO and a PL->PS word FIFO, all at fixed offsets.
- Instantiated inside the top-level Zynq shell on the s00_axi port; downstream PL logic consumes the CSR vector and FIFO handshakes.

Parameters:
- addr_width_p, 10, AXI-Lite address width; only bits [9:2] are decoded.
- data_width_p, 32, AXI-Lite data width; must be 32.
- num_regs_p, 8, number of R/W CSRs; range 1..64.
- fifo_els_p, 16, depth of each FIFO; power of 2, at least 2.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- s_axil_awaddr_i  in  addr_width_p  write address
- s_axil_awprot_i  in  3  ignored
- s_axil_awvalid_i / s_axil_awready_o  in/out  1  AW handshake
- s_axil_wdata_i  in  32  write data
- s_axil_wstrb_i  in  4  byte strobes
- s_axil_wvalid_i / s_axil_wready_o  in/out  1  W handshake
- s_axil_bresp_o  out  2  write response
- s_axil_bvalid_o / s_axil_bready_i  out/in  1  B handshake
- s_axil_araddr_i  in  addr_width_p  read address
- s_axil_arprot_i  in  3  ignored
- s_axil_arvalid_i / s_axil_arready_o  in/out  1  AR handshake
- s_axil_rdata_o  out  32  read data
- s_axil_rresp_o  out  2  read response
- s_axil_rvalid_o / s_axil_rready_i  out/in  1  R handshake
- csr_data_o  out  num_regs_p*32  flattened CSR contents; reg k is at bits [32k+31:32k].
- ps2pl_data_o  out  32  PS->PL FIFO head
- ps2pl_v_o  out  1  head valid
- ps2pl_yumi_i  in  1  pop; legal only when ps2pl_v_o is high
- pl2ps_data_i  in  32  PL->PS FIFO push data
- pl2ps_v_i  in  1  push request
- pl2ps_ready_o  out  1  FIFO not full

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values: all CSRs 0, both FIFOs empty, bvalid/rvalid 0, bresp/rresp 0, rdata 0, awready/wready/arready 1, ps2pl_v_o 0, pl2ps_ready_o 1.
- Reset asserted mid-transaction: any held AW/W/AR state and any pending B/R are dropped on that clock edge.

Address map (word offsets):
- 0x000 .. 4*(num_regs_p-1): R/W CSRs.
- 0x100: PS->PL data. A write pushes the full 32-bit word; wstrb is ignored. A read returns 0.
- 0x104: PS->PL free-entry count, read-only.
- 0x108: PL->PS data. A read pops.
- 0x10C: PL->PS occupancy, read-only.
- Any other offset is a decode error.

Write path:
- AW and W are accepted independently. awready drops after an AW capture until B completes; wready behaves the same for W.
- The write commits on the edge after both AW and W are held. bvalid rises on that same edge.
- bvalid stays high until bready. awready and wready reassert the cycle after the B handshake.
- Minimum write latency: 1 cycle from the last of AW/W to bvalid.
- CSR writes honour wstrb per byte.
- Write to a read-only offset or a decode-error offset: no state change, SLVERR (2'b10).
- Write to 0x100 while the PS->PL FIFO is full: no push, SLVERR.

Read path:
- arready is high when no R is pending.
- On the AR handshake edge, rdata/rresp are registered and rvalid rises. rvalid holds until rready; arready reasserts the cycle after the R handshake.
- Read of 0x108 with the PL->PS FIFO empty: rdata 0, SLVERR, no pop.
- Read of 0x108 with data present: the pop happens on the AR handshake edge.

Simultaneous events:
- A read and a write of the same CSR committing on the same edge: the read returns the old value.
- FIFO push and pop on the same cycle, FIFO full: allowed only via ps2pl_yumi_i/pl2ps push semantics of the FIFO sub-module. pl2ps_ready_o reflects full before the pop.
- Count registers are sampled at AR handshake.
- Pointer and count arithmetic is modulo fifo_els_p. Counts are $clog2(fifo_els_p)+1 bits wide, zero-extended to 32 bits.

Optional Feature:
- Macro: AXIL_CSR_RESP_CHECK_EN.
- Defined: SLVERR on decode error, read-only write, full push and empty pop, as specified above.
- Undefined: bresp/rresp are always OKAY (2'b00). Side-effect suppression is unchanged: no push when full, no pop when empty, and decode-error reads return 0.

Decomposition:
- Package axil_csr_pkg holds:
  - offset localparams: ps2pl_data, ps2pl_free, pl2ps_data, pl2ps_count;
  - the resp enum: OKAY=2'b00, SLVERR=2'b10;
  - a csr_decode_e enum: CSR, PS2PL_DATA, PS2PL_FREE, PL2PS_DATA, PL2PS_CNT, DECERR.
- Sub-module: two instances of bsg_fifo_1r1w_small (width 32, els fifo_els_p).

Test Plan:
- Write 0xDEADBEEF to 0x004 with wstrb 4'b0101, after reset -> bresp OKAY; a readback of 0x004 returns 0x00AD00EF; csr_data_o[63:32] = 0x00AD00EF.
- W presented 3 cycles before AW, then bready held low 2 cycles -> bvalid rises 1 cycle after AW; awready and wready stay 0 until the cycle after the B handshake.
- Push 16 words 1..16 to 0x100 with ps2pl_yumi_i=0, then a 17th write -> first 16 OKAY, 17th SLVERR; 0x104 reads 0; popping via yumi yields 1..16 in order.
- Read 0x108 with the PL->PS FIFO empty -> rdata 0, rresp SLVERR. Then push 0xA5 via pl2ps_v_i -> 0x10C reads 1, 0x108 reads 0xA5 OKAY, 0x10C reads 0.
- Read 0x200 and write 0x3FC -> SLVERR with the macro, OKAY without; no CSR changes either way.
- Assert reset_i for 1 cycle while bvalid is pending and the PS->PL FIFO holds 3 entries -> next cycle bvalid 0, ps2pl_v_o 0, 0x104 reads 16, all CSRs 0.

Source files
------------

// File: rtl/axil_csr_pkg.sv
// Shared address offsets, response/decode enums and helpers for axil_csr_responder.
package axil_csr_pkg;

  localparam logic [9:0] ps2pl_data_off  = 10'h100;
  localparam logic [9:0] ps2pl_free_off  = 10'h104;
  localparam logic [9:0] pl2ps_data_off  = 10'h108;
  localparam logic [9:0] pl2ps_count_off = 10'h10C;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic [2:0] {
    CSR        = 3'd0,
    PS2PL_DATA = 3'd1,
    PS2PL_FREE = 3'd2,
    PL2PS_DATA = 3'd3,
    PL2PS_CNT  = 3'd4,
    DECERR     = 3'd5
  } csr_decode_e;

  // word_i is the word index (address bits [9:2]).
  function automatic csr_decode_e csr_decode(input logic [7:0] word_i, input int num_regs_i);
    csr_decode_e dec;
    case (word_i)
      ps2pl_data_off[9:2]:  dec = PS2PL_DATA;
      ps2pl_free_off[9:2]:  dec = PS2PL_FREE;
      pl2ps_data_off[9:2]:  dec = PL2PS_DATA;
      pl2ps_count_off[9:2]: dec = PL2PS_CNT;
      default:              dec = DECERR;
    endcase
    if (int'(word_i) < num_regs_i) dec = CSR;
    return dec;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_i, input logic [31:0] new_i,
                                             input logic [3:0] strb_i);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb_i[b] ? new_i[8*b +: 8] : old_i[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small synchronous FIFO: push when ready_o, pop via yumi_i; full blocks a push even if a pop coincides.
module bsg_fifo_1r1w_small
  import axil_csr_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [width_p-1:0]      data_i,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  input  logic                    yumi_i,
  output logic [$clog2(els_p):0]  count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                push_s, pop_s;

  assign ready_o = (count_q != cnt_w_lp'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign push_s  = v_i & ready_o;
  assign pop_s   = yumi_i & v_o;

  always_comb begin
    wptr_d  = push_s ? wptr_q + ptr_w_lp'(1) : wptr_q;
    rptr_d  = pop_s  ? rptr_q + ptr_w_lp'(1) : rptr_q;
    count_d = count_q + cnt_w_lp'(push_s) - cnt_w_lp'(pop_s);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/axil_csr_responder.sv
// AXI4-Lite responder with a CSR bank and PS<->PL word FIFOs.
// AXIL_CSR_RESP_CHECK_EN: when defined, error cases answer SLVERR; otherwise every response is OKAY.
module axil_csr_responder
  import axil_csr_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int data_width_p = 32,
  parameter int num_regs_p   = 8,
  parameter int fifo_els_p   = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [addr_width_p-1:0]          s_axil_awaddr_i,
  input  logic [2:0]                       s_axil_awprot_i,
  input  logic                             s_axil_awvalid_i,
  output logic                             s_axil_awready_o,
  input  logic [data_width_p-1:0]          s_axil_wdata_i,
  input  logic [3:0]                       s_axil_wstrb_i,
  input  logic                             s_axil_wvalid_i,
  output logic                             s_axil_wready_o,
  output logic [1:0]                       s_axil_bresp_o,
  output logic                             s_axil_bvalid_o,
  input  logic                             s_axil_bready_i,
  input  logic [addr_width_p-1:0]          s_axil_araddr_i,
  input  logic [2:0]                       s_axil_arprot_i,
  input  logic                             s_axil_arvalid_i,
  output logic                             s_axil_arready_o,
  output logic [data_width_p-1:0]          s_axil_rdata_o,
  output logic [1:0]                       s_axil_rresp_o,
  output logic                             s_axil_rvalid_o,
  input  logic                             s_axil_rready_i,
  output logic [num_regs_p*data_width_p-1:0] csr_data_o,
  output logic [data_width_p-1:0]          ps2pl_data_o,
  output logic                             ps2pl_v_o,
  input  logic                             ps2pl_yumi_i,
  input  logic [data_width_p-1:0]          pl2ps_data_i,
  input  logic                             pl2ps_v_i,
  output logic                             pl2ps_ready_o
);

  localparam int cnt_w_lp = $clog2(fifo_els_p) + 1;
`ifdef AXIL_CSR_RESP_CHECK_EN
  localparam resp_e err_resp_lp = SLVERR;
`else
  localparam resp_e err_resp_lp = OKAY;
`endif

  logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [7:0]              aw_word_q, aw_word_d;
  logic [31:0]             w_data_q, w_data_d;
  logic [3:0]              w_strb_q, w_strb_d;
  logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  resp_e                   bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [num_regs_p-1:0][31:0] csr_q, csr_d;

  logic                    aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  csr_decode_e             wdec_s, rdec_s;
  logic                    ps2pl_push_s, ps2pl_ready_s, pl2ps_pop_s, pl2ps_v_s;
  logic [31:0]             pl2ps_head_s;
  logic [cnt_w_lp-1:0]     ps2pl_count_s, pl2ps_count_s;
  logic                    unused_s;

  assign unused_s = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_awaddr_i, s_axil_araddr_i};

  assign s_axil_awready_o = ~aw_held_q & ~bvalid_q;
  assign s_axil_wready_o  = ~w_held_q & ~bvalid_q;
  assign s_axil_arready_o = ~rvalid_q;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rresp_o   = rresp_q;
  assign s_axil_rdata_o   = rdata_q;
  assign csr_data_o       = csr_q;

  assign aw_hs_s  = s_axil_awvalid_i & s_axil_awready_o;
  assign w_hs_s   = s_axil_wvalid_i & s_axil_wready_o;
  assign ar_hs_s  = s_axil_arvalid_i & s_axil_arready_o;
  assign commit_s = aw_held_q & w_held_q;
  assign wdec_s   = csr_decode(aw_word_q, num_regs_p);
  assign rdec_s   = csr_decode(s_axil_araddr_i[9:2], num_regs_p);

  // Write channel: capture AW/W independently, commit once both are held.
  always_comb begin
    aw_held_d    = aw_hs_s ? 1'b1 : aw_held_q;
    aw_word_d    = aw_hs_s ? s_axil_awaddr_i[9:2] : aw_word_q;
    w_held_d     = w_hs_s ? 1'b1 : w_held_q;
    w_data_d     = w_hs_s ? s_axil_wdata_i : w_data_q;
    w_strb_d     = w_hs_s ? s_axil_wstrb_i : w_strb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    csr_d        = csr_q;
    ps2pl_push_s = 1'b0;
    if (commit_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = OKAY;
      case (wdec_s)
        CSR: begin
          for (int k = 0; k < num_regs_p; k++) begin
            if (aw_word_q == 8'(k)) csr_d[k] = strb_merge(csr_q[k], w_data_q, w_strb_q);
            else                    csr_d[k] = csr_q[k];
          end
        end
        PS2PL_DATA: begin
          if (ps2pl_ready_s) ps2pl_push_s = 1'b1;
          else               bresp_d = err_resp_lp;
        end
        default: bresp_d = err_resp_lp;
      endcase
    end else if (bvalid_q && s_axil_bready_i) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end
  end

  // Read channel: registered response on the AR handshake; PL->PS pop happens on that same edge.
  always_comb begin
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    pl2ps_pop_s = 1'b0;
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rresp_d  = OKAY;
      rdata_d  = '0;
      case (rdec_s)
        CSR: begin
          for (int k = 0; k < num_regs_p; k++) begin
            rdata_d = rdata_d | ((s_axil_araddr_i[9:2] == 8'(k)) ? csr_q[k] : 32'h0);
          end
        end
        PS2PL_DATA: rdata_d = '0;
        PS2PL_FREE: rdata_d = 32'(cnt_w_lp'(fifo_els_p) - ps2pl_count_s);
        PL2PS_DATA: begin
          if (pl2ps_v_s) begin
            rdata_d     = pl2ps_head_s;
            pl2ps_pop_s = 1'b1;
          end else begin
            rresp_d = err_resp_lp;
          end
        end
        PL2PS_CNT: rdata_d = 32'(pl2ps_count_s);
        default:   rresp_d = err_resp_lp;
      endcase
    end else if (rvalid_q && s_axil_rready_i) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      aw_held_q <= 1'b0;
      aw_word_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      csr_q     <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_word_q <= aw_word_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      csr_q     <= csr_d;
    end
  end

  bsg_fifo_1r1w_small #(.width_p(data_width_p), .els_p(fifo_els_p)) ps2pl_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (ps2pl_push_s),
    .ready_o (ps2pl_ready_s),
    .data_i  (w_data_q),
    .v_o     (ps2pl_v_o),
    .data_o  (ps2pl_data_o),
    .yumi_i  (ps2pl_yumi_i),
    .count_o (ps2pl_count_s)
  );

  bsg_fifo_1r1w_small #(.width_p(data_width_p), .els_p(fifo_els_p)) pl2ps_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (pl2ps_v_i),
    .ready_o (pl2ps_ready_o),
    .data_i  (pl2ps_data_i),
    .v_o     (pl2ps_v_s),
    .data_o  (pl2ps_head_s),
    .yumi_i  (pl2ps_pop_s),
    .count_o (pl2ps_count_s)
  );

endmodule

// File: tb/tb_axil_csr_responder.sv
// Self-checking bench for axil_csr_responder: directed cases plus randomized traffic against a queue/array model.
module tb_axil_csr_responder;

  localparam int NREGS = 8;
  localparam int ELS   = 16;
`ifdef AXIL_CSR_RESP_CHECK_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic arvalid = 1'b0, arready, rvalid, rready = 1'b0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [NREGS*32-1:0] csr_data;
  logic [31:0] ps2pl_data, pl2ps_data = '0;
  logic ps2pl_v, ps2pl_yumi = 1'b0, pl2ps_v = 1'b0, pl2ps_ready;

  always #5 clk = ~clk;

  axil_csr_responder dut (
    .clk_i(clk), .reset_i(rst),
    .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid), .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid), .s_axil_rready_i(rready),
    .csr_data_o(csr_data), .ps2pl_data_o(ps2pl_data), .ps2pl_v_o(ps2pl_v), .ps2pl_yumi_i(ps2pl_yumi),
    .pl2ps_data_i(pl2ps_data), .pl2ps_v_i(pl2ps_v), .pl2ps_ready_o(pl2ps_ready)
  );

  int n_assert = 0, n_fail = 0;
  bit cmp_en = 1'b0;
  logic [31:0] m_csr [NREGS];
  logic [31:0] m_ps2pl [$];
  logic [31:0] m_pl2ps [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of a committed write; returns the expected response.
  function automatic logic [1:0] model_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int w = int'(addr[9:2]);
    if (w < NREGS) begin
      for (int b = 0; b < 4; b++) if (strb[b]) m_csr[w][8*b +: 8] = data[8*b +: 8];
      return 2'b00;
    end
    if (w == 'h40) begin
      if (m_ps2pl.size() < ELS) begin
        m_ps2pl.push_back(data);
        return 2'b00;
      end
      return ERR;
    end
    return ERR;
  endfunction

  function automatic void model_read(input logic [9:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int w = int'(addr[9:2]);
    data = 32'h0;
    resp = 2'b00;
    if (w < NREGS) data = m_csr[w];
    else if (w == 'h40) data = 32'h0;
    else if (w == 'h41) data = 32'(ELS - m_ps2pl.size());
    else if (w == 'h42) begin
      if (m_pl2ps.size() > 0) data = m_pl2ps.pop_front();
      else resp = ERR;
    end
    else if (w == 'h43) data = 32'(m_pl2ps.size());
    else resp = ERR;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NREGS; k++) m_csr[k] = 32'h0;
    m_ps2pl.delete();
    m_pl2ps.delete();
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NREGS; k++) check($sformatf("csr_data[%0d]", k), csr_data[32*k +: 32], m_csr[k]);
      check("ps2pl_v", 32'(ps2pl_v), 32'(m_ps2pl.size() != 0));
      if (m_ps2pl.size() != 0) check("ps2pl_data", ps2pl_data, m_ps2pl[0]);
      check("pl2ps_ready", 32'(pl2ps_ready), 32'(m_pl2ps.size() < ELS));
    end
  end

  task automatic wait_hs(input int which, output bit ok);
    int n = 0;
    bit hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = (which == 0) ? awready : (which == 1) ? wready : arready;
      @(posedge clk); #1;
      n++;
    end
    ok = hs;
  endtask

  task automatic axi_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    bit ok_aw, ok_w;
    logic [1:0] exp;
    fork
      begin
        repeat (aw_dly) @(posedge clk);
        #1;
        awaddr = addr; awvalid = 1'b1;
        wait_hs(0, ok_aw);
        awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(posedge clk);
        #1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        wait_hs(1, ok_w);
        wvalid = 1'b0;
      end
    join
    check("aw_w_handshake", 32'({ok_aw, ok_w}), 32'd3);
    check("bvalid_before_commit", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    check("bvalid_latency", 32'(bvalid), 32'd1);
    exp = model_write(addr, data, strb);
    resp = bresp;
    check("bresp", 32'(bresp), 32'(exp));
    repeat (b_dly) begin
      @(posedge clk); #1;
      check("bvalid_hold", 32'(bvalid), 32'd1);
      check("aw_w_ready_low", 32'({awready, wready}), 32'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_drop", 32'(bvalid), 32'd0);
    check("aw_w_ready_back", 32'({awready, wready}), 32'd3);
  endtask

  task automatic axi_read(input logic [9:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit ok;
    logic [31:0] ed;
    logic [1:0] er;
    repeat (ar_dly) @(posedge clk);
    #1;
    araddr = addr; arvalid = 1'b1;
    wait_hs(2, ok);
    arvalid = 1'b0;
    check("ar_handshake", 32'(ok), 32'd1);
    check("rvalid_rise", 32'(rvalid), 32'd1);
    check("arready_low", 32'(arready), 32'd0);
    model_read(addr, ed, er);
    data = rdata;
    resp = rresp;
    check("rdata", rdata, ed);
    check("rresp", 32'(rresp), 32'(er));
    repeat (r_dly) begin
      @(posedge clk); #1;
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, ed);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_drop", 32'(rvalid), 32'd0);
    check("arready_back", 32'(arready), 32'd1);
  endtask

  task automatic ps2pl_pop();
    ps2pl_yumi = 1'b1;
    @(posedge clk); #1;
    ps2pl_yumi = 1'b0;
    void'(m_ps2pl.pop_front());
  endtask

  task automatic pl2ps_push(input logic [31:0] d);
    pl2ps_data = d; pl2ps_v = 1'b1;
    @(posedge clk); #1;
    pl2ps_v = 1'b0;
    if (m_pl2ps.size() < ELS) m_pl2ps.push_back(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [9:0] rand_addr();
    int sel = $urandom_range(0, 9);
    logic [9:0] a;
    if (sel < 5) a = 10'($urandom_range(0, NREGS - 1) * 4);
    else if (sel < 9) a = 10'(32'h100 + (sel - 5) * 4);
    else a = 10'($urandom);
    a[1:0] = 2'($urandom);
    return a;
  endfunction

  initial begin
    logic [1:0] r;
    logic [31:0] d;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    check("reset_bvalid", 32'(bvalid), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_resp", 32'({bresp, rresp}), 32'd0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_readies", 32'({awready, wready, arready}), 32'd7);
    check("reset_fifos", 32'({ps2pl_v, pl2ps_ready}), 32'd1);

    // Strobed CSR write and readback.
    axi_write(10'h004, 32'hDEADBEEF, 4'b0101, 0, 0, 0, r);
    check("t1_bresp", 32'(r), 32'd0);
    axi_read(10'h004, 0, 0, d, r);
    check("t1_rdata", d, 32'h00AD00EF);
    check("t1_csr1", csr_data[63:32], 32'h00AD00EF);

    // W three cycles ahead of AW, B held off two cycles.
    axi_write(10'h008, 32'hCAFEF00D, 4'hF, 3, 0, 2, r);
    check("t2_bresp", 32'(r), 32'd0);

    // Fill PS->PL, overflow, drain.
    for (int i = 1; i <= ELS; i++) begin
      axi_write(10'h100, 32'(i), 4'h0, 0, 0, 0, r);
      check("t3_push_ok", 32'(r), 32'd0);
    end
    axi_write(10'h100, 32'd17, 4'hF, 0, 0, 0, r);
    check("t3_push_full", 32'(r), 32'(ERR));
    axi_read(10'h104, 0, 0, d, r);
    check("t3_free_zero", d, 32'd0);
    for (int i = 1; i <= ELS; i++) begin
      check("t3_pop_order", ps2pl_data, 32'(i));
      ps2pl_pop();
    end

    // PL->PS empty pop, then one entry.
    axi_read(10'h108, 0, 1, d, r);
    check("t4_empty_rdata", d, 32'h0);
    check("t4_empty_resp", 32'(r), 32'(ERR));
    pl2ps_push(32'hA5);
    axi_read(10'h10C, 0, 0, d, r);
    check("t4_count1", d, 32'd1);
    axi_read(10'h108, 0, 0, d, r);
    check("t4_pop_data", d, 32'hA5);
    check("t4_pop_resp", 32'(r), 32'd0);
    axi_read(10'h10C, 0, 0, d, r);
    check("t4_count0", d, 32'd0);

    // Decode errors.
    axi_read(10'h200, 0, 0, d, r);
    check("t5_decerr_rdata", d, 32'h0);
    check("t5_decerr_rresp", 32'(r), 32'(ERR));
    axi_write(10'h3FC, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r);
    check("t5_decerr_bresp", 32'(r), 32'(ERR));
    axi_write(10'h104, 32'h12345678, 4'hF, 1, 0, 0, r);
    check("t5_ro_bresp", 32'(r), 32'(ERR));

    // Read and write of the same CSR on the same edge: read sees old value.
    axi_write(10'h00C, 32'h11111111, 4'hF, 0, 0, 0, r);
    awaddr = 10'h00C; awvalid = 1'b1; wdata = 32'h22222222; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 10'h00C; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    void'(model_write(10'h00C, 32'h22222222, 4'hF));
    check("t6_bvalid", 32'(bvalid), 32'd1);
    check("t6_rvalid", 32'(rvalid), 32'd1);
    check("t6_old_value", rdata, 32'h11111111);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    check("t6_new_value", csr_data[127:96], 32'h22222222);

    // Reset while B pending and PS->PL holding three entries.
    for (int i = 0; i < 3; i++) axi_write(10'h100, 32'(100 + i), 4'hF, 0, 0, 0, r);
    awaddr = 10'h000; awvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    void'(model_write(10'h000, 32'h12345678, 4'hF));
    check("t7_bvalid_pending", 32'(bvalid), 32'd1);
    do_reset();
    check("t7_bvalid_cleared", 32'(bvalid), 32'd0);
    check("t7_ps2pl_v", 32'(ps2pl_v), 32'd0);
    check("t7_csr_zero", csr_data[31:0], 32'h0);
    axi_read(10'h104, 0, 0, d, r);
    check("t7_free_full", d, 32'd16);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      int op = $urandom_range(0, 5);
      case (op)
        0, 1: axi_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 2), r);
        2: axi_read(rand_addr(), $urandom_range(0, 2), $urandom_range(0, 2), d, r);
        3: pl2ps_push($urandom);
        4: if (m_ps2pl.size() > 0) ps2pl_pop();
        default: begin @(posedge clk); #1; end
      endcase
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
